// File: rtl/exe_stage.sv
// Execute stage: ALU, data-sram request, HI/LO ownership and a 32-step restoring divider.
// Optional feature macro: EXE_MUL_EN enables single-cycle mult/multu into HI/LO.
module exe_stage #(
   parameter int          DIV_FAST_ZERO = 1,
   parameter logic [31:0] HILO_RESET    = 32'h0
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ms_allowin,
   output logic         es_allowin,
   input  logic         ds_to_es_valid,
   input  logic [143:0] ds_to_es_bus,
   output logic         es_to_ms_valid,
   output logic [70:0]  es_to_ms_bus,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_wen,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata,
   output logic [31:0]  es_to_ds_result,
   output logic [4:0]   ES_dest,
   output logic         es_load
);

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   logic         es_valid_q;
   logic [143:0] bus_q;
   div_state_t   state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [31:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [31:0]  hi_q, hi_d, lo_q, lo_d;

   logic [1:0]  mul_op, div_op;
   logic [3:0]  hilo_op;
   logic [11:0] alu_op;
   logic        load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we;
   logic [4:0]  dest;
   logic [15:0] imm;
   logic [31:0] rs_value, rt_value, pc;

   assign {mul_op, div_op, hilo_op, alu_op, load_op, src1_is_sa, src1_is_pc, src2_is_imm,
           src2_is_8, gr_we, mem_we, dest, imm, rs_value, rt_value, pc} = bus_q;

   logic es_ready_go, es_leave, div_req;

   assign div_req     = |div_op;
   assign es_ready_go = !(div_req && state_q != DIV_DONE);
   assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);
   assign es_leave    = es_valid_q && es_ready_go && ms_allowin;

   // ---- stage boundary: decode bundle capture ----
   always_ff @(posedge clk) begin
      if (!resetn) begin
         es_valid_q <= 1'b0;
      end else if (es_allowin) begin
         es_valid_q <= ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ds_to_es_valid && es_allowin) begin
         bus_q <= ds_to_es_bus;
      end
   end

   logic        [31:0] src1, src2, alu_res, result;
   logic signed [31:0] src1_s, src2_s;

   assign src1   = src1_is_sa ? {27'd0, imm[10:6]} : (src1_is_pc ? pc : rs_value);
   assign src2   = src2_is_imm ? {{16{imm[15]}}, imm} : (src2_is_8 ? 32'd8 : rt_value);
   assign src1_s = src1;
   assign src2_s = src2;

   always_comb begin
      alu_res = 32'd0;
      unique case (1'b1)
         alu_op[0]:  alu_res = src1 + src2;
         alu_op[1]:  alu_res = src1 - src2;
         alu_op[2]:  alu_res = {31'd0, src1_s < src2_s};
         alu_op[3]:  alu_res = {31'd0, src1 < src2};
         alu_op[4]:  alu_res = src1 & src2;
         alu_op[5]:  alu_res = ~(src1 | src2);
         alu_op[6]:  alu_res = src1 | src2;
         alu_op[7]:  alu_res = src1 ^ src2;
         alu_op[8]:  alu_res = src2 << src1[4:0];
         alu_op[9]:  alu_res = src2 >> src1[4:0];
         alu_op[10]: alu_res = src2_s >>> src1[4:0];
         alu_op[11]: alu_res = {src2[15:0], 16'd0};
         default:    alu_res = 32'd0;
      endcase
   end

   // Divider operates on magnitudes; signs are restored from the held bundle at commit.
   logic        div_signed, div_zero, q_neg, r_neg;
   logic [31:0] dvd_mag, dvs_mag, quo_fix, rem_fix, div_hi, div_lo;
   logic [32:0] shifted;

   assign div_signed = div_op[1];
   assign div_zero   = (rt_value == 32'd0);
   assign dvd_mag    = (div_signed && rs_value[31]) ? (~rs_value + 32'd1) : rs_value;
   assign dvs_mag    = (div_signed && rt_value[31]) ? (~rt_value + 32'd1) : rt_value;
   assign q_neg      = div_signed && (rs_value[31] ^ rt_value[31]);
   assign r_neg      = div_signed && rs_value[31];
   assign quo_fix    = q_neg ? (~quo_q + 32'd1) : quo_q;
   assign rem_fix    = r_neg ? (~rem_q + 32'd1) : rem_q;
   assign div_hi     = div_zero ? rs_value : rem_fix;
   assign div_lo     = div_zero ? 32'hFFFF_FFFF : quo_fix;
   assign shifted    = {rem_q, quo_q[31]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      case (state_q)
         DIV_IDLE: begin
            if (es_valid_q && div_req) begin
               cnt_d   = 5'd0;
               rem_d   = 32'd0;
               quo_d   = dvd_mag;
               dvs_d   = dvs_mag;
               state_d = (DIV_FAST_ZERO != 0 && div_zero) ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            if (shifted >= {1'b0, dvs_q}) begin
               rem_d = shifted[31:0] - dvs_q;
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            if (cnt_q == 5'd31) begin
               state_d = DIV_DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DIV_DONE: begin
            if (es_leave) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

`ifdef EXE_MUL_EN
   logic [63:0] mul_a, mul_b, prod;
   assign mul_a = {{32{mul_op[1] & rs_value[31]}}, rs_value};
   assign mul_b = {{32{mul_op[1] & rt_value[31]}}, rt_value};
   assign prod  = mul_a * mul_b;
`else
   logic unused_mul;
   assign unused_mul = ^mul_op;
`endif

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (es_leave) begin
         if (div_req) begin
            hi_d = div_hi;
            lo_d = div_lo;
         end
`ifdef EXE_MUL_EN
         if (|mul_op) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
         end
`endif
         if (hilo_op[1]) hi_d = rs_value;
         if (hilo_op[0]) lo_d = rs_value;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= DIV_IDLE;
         cnt_q   <= 5'd0;
         hi_q    <= HILO_RESET;
         lo_q    <= HILO_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
   end

   // ---- stage boundary: outputs toward memory and decode ----
   assign result          = hilo_op[3] ? hi_q : (hilo_op[2] ? lo_q : alu_res);
   assign es_to_ms_valid  = es_valid_q && es_ready_go;
   assign es_to_ms_bus    = {load_op, gr_we, dest, result, pc};
   assign data_sram_en    = es_leave && (load_op || mem_we);
   assign data_sram_wen   = {4{mem_we & data_sram_en}};
   assign data_sram_addr  = alu_res;
   assign data_sram_wdata = rt_value;
   assign es_to_ds_result = result;
   assign ES_dest         = dest & {5{es_valid_q && gr_we}};
   assign es_load         = es_valid_q && load_op;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage.
- Registers the decode bundle and computes the ALU result.
- Issues the single data-sram request for loads and stores.
- Owns the HI/LO registers and a 32-step iterative divider that stalls the stage.
- Produces the 71-bit execute-to-memory bus and decode-stage bypass/load-use signals.

Parameters:
- DIV_FAST_ZERO, default 1: when 1, a divide with divisor 0 skips iteration (IDLE->DONE in 1 cycle); when 0 it runs the full 32 steps.
- HILO_RESET, default 32'h0: value loaded into HI and LO on reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ms_allowin  in  1  memory stage can accept.
- es_allowin  out  1  this stage can accept.
- ds_to_es_valid  in  1  decode bundle valid.
- ds_to_es_bus  in  144  bundle, MSB first: mul_op[1:0]{mult,multu}, div_op[1:0]{div,divu}, hilo_op[3:0]{mfhi,mflo,mthi,mtlo}, alu_op[11:0], load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0].
- es_to_ms_valid  out  1  bundle valid to memory stage.
- es_to_ms_bus  out  71  {res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- data_sram_en  out  1  request strobe.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  address.
- data_sram_wdata  out  32  store data.
- es_to_ds_result  out  32  forwarded result.
- ES_dest  out  5  forwarded destination; 0 when not writing.
- es_load  out  1  load in stage, for load-use stall.

Behaviour:
- Reset: es_valid=0, divider IDLE, step counter=0, HI=LO=HILO_RESET. All outputs are derived, so on reset: es_to_ms_valid=0, data_sram_en=0, wen=0, ES_dest=0, es_load=0.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_valid <= ds_to_es_valid when es_allowin.
  - Bundle register is latched only on ds_to_es_valid && es_allowin.
  - es_to_ms_valid = es_valid && es_ready_go.
- ALU:
  - alu_op one-hot, bit0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub wrap modulo 2^32; no overflow trap.
  - Shifts use src1[4:0] as the amount.
  - src1 = sa (imm[10:6] zero-extended) | pc | rs. src2 = sign-extended imm | 32'd8 | rt.
- Result mux: mfhi -> HI, mflo -> LO, else ALU result. res_from_mem = load_op.
- Memory request:
  - en = es_valid && es_ready_go && ms_allowin && (load_op || mem_we), so exactly one request per instruction.
  - wen = {4{mem_we}} & {4{en}}. addr = ALU result. wdata = rt_value.
- Bypass:
  - ES_dest = dest & {5{es_valid && gr_we}}.
  - es_load = es_valid && load_op.
  - es_to_ds_result = final result.
- Divider FSM (IDLE, BUSY, DONE):
  - IDLE->BUSY when es_valid && div_op!=0. Operands are captured as magnitudes (div) or raw values (divu), and the counter is cleared.
  - BUSY does one restoring step per cycle. After step 31, the state moves to DONE.
  - DONE->IDLE on es_ready_go && ms_allowin.
  - es_ready_go = !(div_op!=0 && state!=DONE).
  - A divide stays in the stage at least 34 cycles (1 IDLE + 32 BUSY + 1 DONE). DONE holds indefinitely while ms_allowin=0.
  - Signed fix-up: quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: LO=32'hFFFFFFFF, HI=rs_value. If DIV_FAST_ZERO=1, IDLE->DONE directly (2 cycles in stage).
- HI/LO commit: written only on the cycle the instruction leaves the stage (es_valid && es_ready_go && ms_allowin).
  - div/divu: HI=remainder, LO=quotient.
  - mthi: HI=rs. mtlo: LO=rs.
  - An mfhi directly after mthi reads the committed value (the commit has happened by then).
- Reset mid-divide: FSM returns to IDLE, no HI/LO write, and the instruction is discarded.

Optional Feature:
- EXE_MUL_EN defined: mult/multu compute a 64-bit product combinationally (signed/unsigned) and commit HI=prod[63:32], LO=prod[31:0] under the same commit rule. No stall.
- Undefined: mul_op is ignored; the instruction passes as a no-op with HI/LO unchanged.

Test Plan:
- addu, rs=32'h7FFFFFFF, rt=1, gr_we, dest=5 -> next-cycle bus result 32'h80000000, dest=5, ES_dest=5 while in stage.
- div, rs=-7, rt=2 -> es_ready_go low for 33 cycles; then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; the following mflo returns 32'hFFFFFFFD.
- divu, rs=100, rt=7, with ms_allowin held 0 for 5 cycles in DONE -> stall holds, HI/LO unchanged until release; then LO=14, HI=2 written once.
- div by 0 with DIV_FAST_ZERO=1, rs=9 -> leaves after 2 cycles, LO=32'hFFFFFFFF, HI=9. resetn low during BUSY of another divide -> es_valid=0 next cycle, HI/LO=HILO_RESET.
- sw, rs=32'h1000, imm=4, rt=32'hDEADBEEF, ms_allowin toggling -> exactly one cycle of en=1, wen=4'hF, addr=32'h1004, wdata=32'hDEADBEEF. lw -> es_load=1, wen=0, res_from_mem=1.
- With EXE_MUL_EN: mult rs=-3, rt=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. Without EXE_MUL_EN -> HI/LO unchanged.
